// File: rtl/flash_prom_arbiter_if.sv
`default_nettype none
// flash_prom_arbiter_if: the requester-side bus of the two read ports of flash_prom_arbiter.
interface flash_prom_arbiter_if;
  logic        m0_req;
  logic [16:0] m0_addr;
  logic        m0_byte;
  logic        m0_ack;
  logic [15:0] m0_data;
  logic        m1_req;
  logic [16:0] m1_addr;
  logic        m1_byte;
  logic        m1_ack;
  logic [15:0] m1_data;

  modport master (
    output m0_req, m0_addr, m0_byte, m1_req, m1_addr, m1_byte,
    input  m0_ack, m0_data, m1_ack, m1_data
  );

  modport slave (
    input  m0_req, m0_addr, m0_byte, m1_req, m1_addr, m1_byte,
    output m0_ack, m0_data, m1_ack, m1_data
  );
endinterface
`default_nettype wire

// File: rtl/flash_prom_arbiter.sv
`default_nettype none
// flash_prom_arbiter: two-port arbiter and wait-stated read sequencer for the board NOR flash PROM.
// Optional macro FLASH_ARB_RR_EN selects round-robin tie breaking; otherwise port 0 has fixed priority.
module flash_prom_arbiter #(
  parameter int WAIT_CYC = 3
) (
  input  logic                       sys_clk,
  input  logic                       reset_n,
  flash_prom_arbiter_if.slave        bus,
  output logic                       busy,
  output logic [20:0]                NF_A,
  input  logic [15:0]                NF_D,
  output logic                       NF_WE,
  output logic                       NF_CE,
  output logic                       NF_OE,
  output logic                       NF_BYTE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [15:0] nf_addr;
  logic [15:0] nf_addr_nxt;
  logic        gnt;
  logic        a0;
  logic        byte_acc;
  logic [7:0]  word0_hi;
  logic [15:0] m0_data_q;
  logic [15:0] m1_data_q;
  logic [15:0] rd_data;
  logic        pick1;
  logic        grant_en;
  logic        word0_ld;
  logic        data_ld;
  logic [16:0] sel_addr;
  logic        sel_byte;

`ifdef FLASH_ARB_RR_EN
  logic last_gnt;

  // On a tie the port that was not granted last time wins.
  assign pick1 = bus.m1_req && (!bus.m0_req || !last_gnt);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= 1'b1;
    end else if (grant_en) begin
      last_gnt <= pick1;
    end
  end
`else
  assign pick1 = bus.m1_req && !bus.m0_req;
`endif

  assign sel_addr = pick1 ? bus.m1_addr : bus.m0_addr;
  assign sel_byte = pick1 ? bus.m1_byte : bus.m0_byte;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    nf_addr_nxt = nf_addr;
    grant_en    = 1'b0;
    word0_ld    = 1'b0;
    data_ld     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          grant_en    = 1'b1;
          nf_addr_nxt = sel_addr[16:1];
          cnt_nxt     = 4'(WAIT_CYC);
          state_nxt   = RD0;
        end
      end
      RD0: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          word0_ld = 1'b1;
          if (!byte_acc && a0) begin
            nf_addr_nxt = nf_addr + 16'd1;
            cnt_nxt     = 4'(WAIT_CYC);
            state_nxt   = RD1;
          end else begin
            data_ld   = 1'b1;
            state_nxt = ACK;
          end
        end
      end
      RD1: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          data_ld   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NF_D holds word0 for single reads and word1 during the second half of a split read.
  always_comb begin
    case ({byte_acc, a0})
      2'b10:   rd_data = {{8{NF_D[7]}}, NF_D[7:0]};
      2'b11:   rd_data = {{8{NF_D[15]}}, NF_D[15:8]};
      2'b00:   rd_data = NF_D;
      default: rd_data = {NF_D[7:0], word0_hi};
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 4'd0;
      nf_addr   <= 16'd0;
      gnt       <= 1'b0;
      a0        <= 1'b0;
      byte_acc  <= 1'b0;
      word0_hi  <= 8'd0;
      m0_data_q <= 16'd0;
      m1_data_q <= 16'd0;
    end else begin
      cnt     <= cnt_nxt;
      nf_addr <= nf_addr_nxt;
      if (grant_en) begin
        gnt      <= pick1;
        a0       <= sel_addr[0];
        byte_acc <= sel_byte;
      end
      if (word0_ld) begin
        word0_hi <= NF_D[15:8];
      end
      if (data_ld && !gnt) begin
        m0_data_q <= rd_data;
      end
      if (data_ld && gnt) begin
        m1_data_q <= rd_data;
      end
    end
  end

  assign bus.m0_ack  = (state == ACK) && !gnt;
  assign bus.m1_ack  = (state == ACK) && gnt;
  assign bus.m0_data = m0_data_q;
  assign bus.m1_data = m1_data_q;
  assign busy        = (state != IDLE);
  assign NF_A        = {5'b0, nf_addr};
  assign NF_WE       = 1'b1;
  assign NF_CE       = 1'b0;
  assign NF_OE       = 1'b0;
  assign NF_BYTE     = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_flash_prom_arbiter.sv
`default_nettype none
// Self-checking bench for flash_prom_arbiter against a byte-addressed flash model.
module tb_flash_prom_arbiter;
  localparam int W = 3;
`ifdef FLASH_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        busy;
  logic [20:0] NF_A;
  logic [15:0] NF_D;
  logic        NF_WE, NF_CE, NF_OE, NF_BYTE;
  logic [15:0] mem [0:65535];
  logic [20:0] nfa_trace [$];
  int          checks = 0;
  int          errors = 0;
  bit          tb_last = 1'b1;

  flash_prom_arbiter_if bus ();

  flash_prom_arbiter #(.WAIT_CYC(W)) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .NF_A    (NF_A),
    .NF_D    (NF_D),
    .NF_WE   (NF_WE),
    .NF_CE   (NF_CE),
    .NF_OE   (NF_OE),
    .NF_BYTE (NF_BYTE)
  );

  always #5 sys_clk = ~sys_clk;

  assign NF_D = mem[NF_A[15:0]];

  // Flash viewed as a little-endian byte array of 2^17 bytes.
  function automatic logic [7:0] byte_at(input logic [16:0] a);
    logic [15:0] w;
    w = mem[a[16:1]];
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [15:0] exp_data(input logic [16:0] a, input logic b);
    logic [7:0] lo;
    lo = byte_at(a);
    if (b) return {{8{lo[7]}}, lo};
    return {byte_at(a + 17'd1), lo};
  endfunction

  function automatic int exp_lat(input logic [16:0] a, input logic b);
    return (b || !a[0]) ? W + 2 : 2 * W + 3;
  endfunction

  function automatic int exp_port(input logic r0, input logic r1);
    if (!r1) return 0;
    if (!r0) return 1;
    return (RR && !tb_last) ? 1 : 0;
  endfunction

  task automatic start(input logic r0, input logic r1, input logic [16:0] a0, input logic [16:0] a1,
                       input logic b0, input logic b1);
    @(negedge sys_clk);
    bus.m0_req = r0; bus.m0_addr = a0; bus.m0_byte = b0;
    bus.m1_req = r1; bus.m1_addr = a1; bus.m1_byte = b1;
  endtask

  // Latency k means the ack is seen on the k-th falling edge after the sampling edge.
  task automatic wait_ack(output int port, output int lat, output logic [15:0] d);
    port = -1;
    lat  = 0;
    d    = 16'hxxxx;
    nfa_trace.delete();
    @(posedge sys_clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge sys_clk);
      nfa_trace.push_back(NF_A);
      if (bus.m0_ack || bus.m1_ack) begin
        port = (bus.m0_ack && bus.m1_ack) ? 2 : (bus.m1_ack ? 1 : 0);
        d    = bus.m1_ack ? bus.m1_data : bus.m0_data;
        lat  = k;
        break;
      end
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_byte = 1'b0;
    bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_byte = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({bus.m0_ack, bus.m1_ack, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ack_busy: got %b expected 000", {bus.m0_ack, bus.m1_ack, busy});
    end
    checks++;
    if ({bus.m0_data, bus.m1_data} !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 00000000", {bus.m0_data, bus.m1_data});
    end
    checks++;
    if (NF_A !== 21'h0) begin
      errors++; $display("FAIL reset_nf_a: got %h expected 0", NF_A);
    end
    checks++;
    if ({NF_WE, NF_CE, NF_OE, NF_BYTE} !== 4'b1001) begin
      errors++; $display("FAIL flash_ctrl_pins: got %b expected 1001", {NF_WE, NF_CE, NF_OE, NF_BYTE});
    end
    reset_n = 1'b1;
    tb_last = 1'b1;
  endtask

  task automatic test_byte_read();
    int p, l;
    logic [15:0] d;
    mem[0] = 16'h80AB;
    start(1'b1, 1'b0, 17'h00001, 17'h0, 1'b1, 1'b0);
    wait_ack(p, l, d);
    checks++;
    if (p !== 0 || d !== 16'hFF80 || l !== W + 2) begin
      errors++; $display("FAIL byte_odd: port %0d data %h lat %0d expected port 0 data ff80 lat %0d", p, d, l, W + 2);
    end
    checks++;
    if (nfa_trace[0] !== 21'h0 || nfa_trace[W] !== 21'h0) begin
      errors++; $display("FAIL byte_odd_nf_a: got %h/%h expected 0", nfa_trace[0], nfa_trace[W]);
    end
    start(1'b1, 1'b0, 17'h00000, 17'h0, 1'b1, 1'b0);
    wait_ack(p, l, d);
    checks++;
    if (p !== 0 || d !== 16'hFFAB || l !== W + 2) begin
      errors++; $display("FAIL byte_even: port %0d data %h lat %0d expected port 0 data ffab lat %0d", p, d, l, W + 2);
    end
    tb_last = 1'b0;
  endtask

  task automatic test_split_word();
    int p, l;
    logic [15:0] d, prev0;
    mem[1] = 16'h1234;
    mem[2] = 16'hCD56;
    prev0 = bus.m0_data;
    start(1'b0, 1'b1, 17'h0, 17'h00003, 1'b0, 1'b0);
    wait_ack(p, l, d);
    checks++;
    if (p !== 1 || d !== 16'h5612 || l !== 2 * W + 3) begin
      errors++; $display("FAIL split_word: port %0d data %h lat %0d expected port 1 data 5612 lat %0d", p, d, l, 2 * W + 3);
    end
    checks++;
    if (l == 2 * W + 3 && (nfa_trace[0] !== 21'h1 || nfa_trace[W] !== 21'h1 || nfa_trace[W + 1] !== 21'h2)) begin
      errors++; $display("FAIL split_nf_a: got %h %h %h expected 1 1 2", nfa_trace[0], nfa_trace[W], nfa_trace[W + 1]);
    end
    checks++;
    if (bus.m0_data !== prev0) begin
      errors++; $display("FAIL split_other_port: m0_data %h expected %h", bus.m0_data, prev0);
    end
    tb_last = 1'b1;
  endtask

  task automatic test_wrap();
    int p, l;
    logic [15:0] d, e;
    logic [15:0] w0, w1;
    w0 = mem[16'hFFFF];
    w1 = mem[16'h0000];
    e  = {w1[7:0], w0[15:8]};
    start(1'b1, 1'b0, 17'h1FFFF, 17'h0, 1'b0, 1'b0);
    wait_ack(p, l, d);
    checks++;
    if (p !== 0 || d !== e || l !== 2 * W + 3) begin
      errors++; $display("FAIL wrap_word: port %0d data %h lat %0d expected port 0 data %h lat %0d", p, d, l, e, 2 * W + 3);
    end
    checks++;
    if (l == 2 * W + 3 && (nfa_trace[0] !== 21'h0FFFF || nfa_trace[W + 1] !== 21'h0)) begin
      errors++; $display("FAIL wrap_nf_a: got %h then %h expected 0ffff then 0", nfa_trace[0], nfa_trace[W + 1]);
    end
    tb_last = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [16:0] a0, a1;
    logic b0, b1;
    int n, p, ep;
    logic [15:0] d;
    a0 = 17'($urandom); a1 = 17'($urandom);
    b0 = 1'($urandom);  b1 = 1'($urandom);
    start(1'b1, 1'b1, a0, a1, b0, b1);
    n = 0;
    for (int c = 0; c < 300 && n < 6; c++) begin
      @(negedge sys_clk);
      if (bus.m0_ack || bus.m1_ack) begin
        p  = (bus.m0_ack && bus.m1_ack) ? 2 : (bus.m1_ack ? 1 : 0);
        d  = bus.m1_ack ? bus.m1_data : bus.m0_data;
        ep = exp_port(1'b1, 1'b1);
        checks++;
        if (p !== ep || d !== exp_data(ep == 1 ? a1 : a0, ep == 1 ? b1 : b0)) begin
          errors++; $display("FAIL arb_grant%0d: port %0d data %h expected port %0d data %h", n, p, d, ep,
                             exp_data(ep == 1 ? a1 : a0, ep == 1 ? b1 : b0));
        end
        tb_last = (ep == 1);
        n++;
        if (n == 6) begin
          bus.m0_req = 1'b0;
          bus.m1_req = 1'b0;
        end
      end
    end
    checks++;
    if (n !== 6) begin
      errors++; $display("FAIL arb_timeout: got %0d acks expected 6", n);
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_access();
    logic [16:0] a;
    int p, l, stray;
    logic [15:0] d;
    a = 17'($urandom) | 17'h1;
    start(1'b1, 1'b0, a, 17'h0, 1'b0, 1'b0);
    @(posedge sys_clk);
    for (int k = 1; k <= W + 3; k++) @(negedge sys_clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.m0_ack, bus.m1_ack, busy, NF_A, bus.m0_data, bus.m1_data} !== 56'h0) begin
      errors++; $display("FAIL async_reset: ack %b%b busy %b nf_a %h data %h/%h expected all 0",
                         bus.m0_ack, bus.m1_ack, busy, NF_A, bus.m0_data, bus.m1_data);
    end
    stray = 0;
    repeat (2) begin
      @(negedge sys_clk);
      if (bus.m0_ack || bus.m1_ack) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL reset_no_ack: got %0d acks expected 0", stray);
    end
    reset_n = 1'b1;
    tb_last = 1'b1;
    wait_ack(p, l, d);
    checks++;
    if (p !== 0 || d !== exp_data(a, 1'b0) || l !== 2 * W + 3) begin
      errors++; $display("FAIL after_reset: port %0d data %h lat %0d expected port 0 data %h lat %0d",
                         p, d, l, exp_data(a, 1'b0), 2 * W + 3);
    end
    tb_last = 1'b0;
  endtask

  task automatic test_req_drop();
    logic [16:0] a;
    logic b;
    int acks, ack_at;
    a = 17'($urandom); b = 1'($urandom);
    start(1'b1, 1'b0, a, 17'h0, b, 1'b0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.m0_req = 1'b0;
    acks = 0; ack_at = 0;
    for (int k = 2; k <= 3 * W + 12; k++) begin
      @(negedge sys_clk);
      if (bus.m0_ack || bus.m1_ack) begin
        acks++;
        ack_at = k;
      end
    end
    checks++;
    if (acks !== 1 || ack_at !== exp_lat(a, b) || busy !== 1'b0) begin
      errors++; $display("FAIL req_drop: %0d acks at %0d busy %b expected 1 ack at %0d busy 0",
                         acks, ack_at, busy, exp_lat(a, b));
    end
    checks++;
    if (bus.m0_data !== exp_data(a, b)) begin
      errors++; $display("FAIL req_drop_data: got %h expected %h", bus.m0_data, exp_data(a, b));
    end
    tb_last = 1'b0;
  endtask

  task automatic test_random();
    logic [16:0] a0, a1, ea;
    logic b0, b1, eb, r0, r1;
    logic [1:0] r;
    logic [15:0] d, prev0, prev1, other, prev_other;
    int p, l, ep;
    for (int i = 0; i < 30; i++) begin
      r  = 2'($urandom_range(1, 3));
      r0 = r[0]; r1 = r[1];
      a0 = 17'($urandom); a1 = 17'($urandom);
      b0 = 1'($urandom);  b1 = 1'($urandom);
      prev0 = bus.m0_data; prev1 = bus.m1_data;
      ep = exp_port(r0, r1);
      ea = (ep == 1) ? a1 : a0;
      eb = (ep == 1) ? b1 : b0;
      start(r0, r1, a0, a1, b0, b1);
      wait_ack(p, l, d);
      checks++;
      if (p !== ep || d !== exp_data(ea, eb) || l !== exp_lat(ea, eb)) begin
        errors++; $display("FAIL random%0d: port %0d data %h lat %0d expected port %0d data %h lat %0d",
                           i, p, d, l, ep, exp_data(ea, eb), exp_lat(ea, eb));
      end
      other      = (ep == 1) ? bus.m0_data : bus.m1_data;
      prev_other = (ep == 1) ? prev0 : prev1;
      checks++;
      if (other !== prev_other) begin
        errors++; $display("FAIL random%0d_other_port: got %h expected %h", i, other, prev_other);
      end
      tb_last = (ep == 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    test_reset();
    test_byte_read();
    test_split_word();
    test_wrap();
    test_arbitration();
    test_reset_mid_access();
    test_req_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_prom_arbiter.md
# flash_prom_arbiter

Shares the single read-only parallel NOR flash PROM on the Spartan-3AN board between two independent requesters: port 0 for CPU instruction/data fetch, and port 1 for a ROM shadow-copy or video-font engine. The block arbitrates per access and runs a wait-stated flash read sequence. It performs one flash word read, or two for odd-address word accesses, and returns byte (sign-extended) or word data with a one-cycle acknowledge. It sits between the requester logic and the NF_* board pins, all in the sys_clk domain.

## Interface
- WAIT_CYC, 3, flash access wait cycles: NF_A is stable for WAIT_CYC+1 cycles before NF_D is sampled; legal range 1..15.
- sys_clk  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  port 0 request; addr and byte are held stable until ack.
- m0_addr  in  17  port 0 byte address.
- m0_byte  in  1  1 = byte access, 0 = word access.
- m0_ack  out  1  one-cycle pulse; m0_data is valid in the same cycle.
- m0_data  out  16  port 0 read data, held until the next m0_ack.
- m1_req, m1_addr, m1_byte, m1_ack, m1_data: identical to the port 0 signals, for port 1.
- busy  out  1  high while any access is in progress (state ≠ IDLE).
- NF_A  out  21  flash word address = {5'b0, word address[15:0]}.
- NF_D  in  16  flash read data.
- NF_WE, NF_CE, NF_OE, NF_BYTE  out  1 each  constant 1, 0, 0, 1.

## Operation
- States: IDLE, RD0, RD1, ACK.
- IDLE
  - If any req is high, the grant rule selects a port, and its addr and byte are latched.
  - nf_addr <= addr[16:1].
  - The wait counter is loaded with WAIT_CYC.
  - Next state is RD0.
- RD0
  - The counter decrements each cycle.
  - On the cycle the counter reaches 0: word0 <= NF_D.
  - If the access is a word access with addr[0]=1: nf_addr <= addr[16:1]+1, wrapping 16 bits (0xFFFF to 0x0000), the counter is reloaded, and next state is RD1.
  - Otherwise next state is ACK.
- RD1: same counting; at 0, word1 <= NF_D[7:0], and next state is ACK.
- ACK
  - The granted port's ack is 1 for exactly this cycle.
  - The data register is updated at the edge entering ACK.
  - Next state is IDLE.
  - Arbitration happens only in IDLE, so there is always at least one IDLE cycle between accesses.
- Data formatting:
  - Byte access, a0=0: {{8{word0[7]}}, word0[7:0]}.
  - Byte access, a0=1: {{8{word0[15]}}, word0[15:8]}.
  - Word access, a0=0: word0.
  - Word access, a0=1: {word1, word0[15:8]}.
- Port data registers: only the granted port's data register changes. The other port's data register is never disturbed.
- Req dropped mid-access: the access completes and ack still pulses.
- Req held high after ack: it is treated as a new request at the next IDLE.
- Async reset mid-access: the block returns to IDLE immediately and the access is abandoned with no ack.
- Reset values:
  - m0_ack and m1_ack are 0.
  - m0_data and m1_data are 0.
  - NF_A is 0.
  - busy is 0.
  - The last-grant register is 1, so port 0 wins the first tie.

## Timing
- Let T be the edge at which IDLE samples req.
- NF_A is valid from T and is stable for WAIT_CYC+1 cycles.
- Single-read access: ack is high in cycle T+WAIT_CYC+2. With WAIT_CYC=3 that is 5 cycles.
- Split (odd word) access: ack is high in cycle T+2·WAIT_CYC+3. With WAIT_CYC=3 that is 9 cycles.
- Back-to-back throughput for a single port: one single-read access per WAIT_CYC+3 cycles.
- busy is high from T+1 through the ACK cycle inclusive.

## Configuration
- FLASH_ARB_RR_EN defined: round-robin arbitration.
  - On a tie in IDLE, the port not granted last wins.
  - The last-grant register updates on every grant.
- FLASH_ARB_RR_EN undefined: fixed priority, and port 0 always wins a tie.
  - Port 1 can be starved.
  - The last-grant register is not implemented.

## Test plan
- Reset, then port 0 byte reads at addr 0x00001 with flash word 0 = 0x80AB -> m0_data=0xFF80, ack at T+5; at addr 0x00000 -> 0xFFAB.
- Port 1 word read at addr 0x00003, flash word1=0x1234 and word2=0xCD56 -> NF_A shows 0x1 then 0x2, m1_data=0x5612, ack at T+9, m0_data unchanged.
- Word read at addr 0x1FFFF -> second NF_A = 0x00000 (wrap), data = {word0x0000[7:0], word0xFFFF[15:8]}.
- Both reqs held high continuously with FLASH_ARB_RR_EN defined -> grants alternate 0,1,0,1; without the macro -> only port 0 is acked.
- Assert reset_n=0 in RD1 of a split read -> outputs return to reset values asynchronously, no ack; after release, a pending req is serviced normally.
- Drop m0_req one cycle after grant -> m0_ack still pulses once; no second access starts.
